// File: rtl/pipelinedefs.sv
// Shared pipeline definitions: MA control field bit positions and access-size encodings.
package pipelinedefs;

  localparam int unsigned WB_W = 3;
  localparam int unsigned MA_W = 5;

  // Bit positions inside the 5-bit MA control field
  localparam int unsigned MA_EN   = 0;
  localparam int unsigned MA_RW   = 1;
  localparam int unsigned MA_SIZE = 2;  // two bits: [3:2]
  localparam int unsigned MA_UNS  = 4;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane logic for the MA stage.
//  Store side: replicates store data into lanes, decodes byte enables, flags misalignment / reserved size.
//  Load side : selects the addressed lane of the read word and sign- or zero-extends it.
// Ports:
//  st_size, st_off, st_src     store-side size, low address bits, 32-bit store source
//  wdata_c, be_c, fault_c      replicated write data, byte enables, alignment/size fault
//  ld_size, ld_off, ld_uns     load-side size, low address bits, unsigned flag
//  ld_rdata, ld_val_c          raw read word, formatted load result
module mem_lane_fmt
  import pipelinedefs::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]                  st_size,
  input  logic [$clog2(DATA_W/8)-1:0] st_off,
  input  logic [31:0]                 st_src,
  output logic [DATA_W-1:0]           wdata_c,
  output logic [DATA_W/8-1:0]         be_c,
  output logic                        fault_c,
  input  logic [1:0]                  ld_size,
  input  logic [$clog2(DATA_W/8)-1:0] ld_off,
  input  logic                        ld_uns,
  input  logic [DATA_W-1:0]           ld_rdata,
  output logic [DATA_W-1:0]           ld_val_c
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  // Halfword / word lane bases: offset rounded down to the access size
  logic [OFF_W-1:0] st_off_h, st_off_w, ld_off_h, ld_off_w;
  assign st_off_h = st_off & ~OFF_W'(1);
  assign st_off_w = st_off & ~OFF_W'(3);
  assign ld_off_h = ld_off & ~OFF_W'(1);
  assign ld_off_w = ld_off & ~OFF_W'(3);

  // Store lanes and byte enables
  always_comb begin
    wdata_c = '0;
    be_c    = '0;
    fault_c = 1'b0;
    case (st_size)
      SZ_B: begin
        wdata_c = {NB{st_src[7:0]}};
        be_c    = NB'(1) << st_off;
      end
      SZ_H: begin
        wdata_c = {(DATA_W/16){st_src[15:0]}};
        be_c    = NB'(3) << st_off_h;
        fault_c = st_off[0];
      end
      SZ_W: begin
        wdata_c = {(DATA_W/32){st_src}};
        be_c    = NB'(15) << st_off_w;
        fault_c = |st_off[1:0];
      end
      default: fault_c = 1'b1;
    endcase
  end

  // Lane extraction for loads
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_w;
  assign ld_b = 8'(ld_rdata >> {ld_off, 3'b000});
  assign ld_h = 16'(ld_rdata >> {ld_off_h, 3'b000});
  assign ld_w = 32'(ld_rdata >> {ld_off_w, 3'b000});

  always_comb begin
    ld_val_c = '0;
    case (ld_size)
      SZ_B:    ld_val_c = ld_uns ? DATA_W'(ld_b) : DATA_W'($signed(ld_b));
      SZ_H:    ld_val_c = ld_uns ? DATA_W'(ld_h) : DATA_W'($signed(ld_h));
      SZ_W:    ld_val_c = ld_uns ? DATA_W'(ld_w) : DATA_W'($signed(ld_w));
      default: ld_val_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between EX/MEM and MA/WB.
//  Issues byte/half/word accesses over a req/ack interface, stalls upstream while an access is
//  outstanding, raises miss on timeout and misaligned on alignment/size faults.
// Ports:
//  Clk, Rst                         clock, asynchronous active-high reset
//  in_valid, WB_in, MA_in, ...      EX/MEM instruction fields and store-data forwarding
//  mem_req/we/addr/wdata/be         registered memory request, held until mem_ack
//  mem_ack, mem_rdata               one-cycle completion with read data
//  stall                            combinational upstream freeze
//  out_valid, PC_out ... mem_out    registered MA/WB fields
//  EX_MEM_Rs2, EX_MEM_MA            combinational copies for the forwarding unit
//  miss, misaligned                 one-cycle fault pulses
module mem_access_stage
  import pipelinedefs::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  in_valid,
  input  logic [WB_W-1:0]       WB_in,
  input  logic [MA_W-1:0]       MA_in,
  input  logic [DATA_W-1:0]     ALU_rsl_in,
  input  logic [DATA_W-1:0]     Rs2_val,
  input  logic [REG_AW-1:0]     Rs2_address,
  input  logic [DATA_W-1:0]     PC_in,
  input  logic [REG_AW-1:0]     Rdst_in,
  input  logic [DATA_W-1:0]     mux_wb,
  input  logic                  OP1_MemS,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     PC_out,
  output logic [REG_AW-1:0]     Rdst_out,
  output logic [DATA_W-1:0]     ALU_rsl_out,
  output logic [WB_W-1:0]       WB_out,
  output logic [DATA_W-1:0]     mem_out,
  output logic [REG_AW-1:0]     EX_MEM_Rs2,
  output logic [MA_W-1:0]       EX_MEM_MA,
  output logic                  miss,
  output logic                  misaligned
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = 8;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Instruction fields held for the duration of an access
  logic [DATA_W-1:0] pc_q, alu_q;
  logic [REG_AW-1:0] rdst_q;
  logic [WB_W-1:0]   wb_q;
  logic [1:0]        ld_size_q;
  logic              ld_uns_q;

  logic              pass_c, fault_issue_c, issue_c, done_c, miss_c;
  logic [DATA_W-1:0] st_src, wdata_c, ld_val_c;
  logic [NB-1:0]     be_c;
  logic              fault_c;

  assign st_src     = OP1_MemS ? mux_wb : Rs2_val;
  assign EX_MEM_Rs2 = Rs2_address;
  assign EX_MEM_MA  = MA_in;

  mem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .st_size  (MA_in[MA_SIZE +: 2]),
    .st_off   (ALU_rsl_in[OFF_W-1:0]),
    .st_src   (st_src[31:0]),
    .wdata_c  (wdata_c),
    .be_c     (be_c),
    .fault_c  (fault_c),
    .ld_size  (ld_size_q),
    .ld_off   (alu_q[OFF_W-1:0]),
    .ld_uns   (ld_uns_q),
    .ld_rdata (mem_rdata),
    .ld_val_c (ld_val_c)
  );

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and per-cycle action strobes
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pass_c        = 1'b0;
    fault_issue_c = 1'b0;
    issue_c       = 1'b0;
    done_c        = 1'b0;
    miss_c        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          if (!MA_in[MA_EN]) begin
            pass_c = 1'b1;
          end else if (fault_c) begin
            fault_issue_c = 1'b1;
          end else begin
            issue_c = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Ack has priority over a timeout in the same cycle
        if (mem_ack) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          miss_c  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Released in the completing cycle so upstream advances on the same edge
  assign stall = (state_q == ST_WAIT) && !done_c && !miss_c;

  // Memory request, latched instruction and MA/WB output registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      out_valid   <= 1'b0;
      PC_out      <= '0;
      Rdst_out    <= '0;
      ALU_rsl_out <= '0;
      WB_out      <= '0;
      mem_out     <= '0;
      miss        <= 1'b0;
      misaligned  <= 1'b0;
      pc_q        <= '0;
      alu_q       <= '0;
      rdst_q      <= '0;
      wb_q        <= '0;
      ld_size_q   <= '0;
      ld_uns_q    <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      miss       <= 1'b0;
      misaligned <= 1'b0;

      if (pass_c || fault_issue_c) begin
        out_valid   <= 1'b1;
        misaligned  <= fault_issue_c;
        PC_out      <= PC_in;
        Rdst_out    <= Rdst_in;
        ALU_rsl_out <= ALU_rsl_in;
        WB_out      <= fault_issue_c ? '0 : WB_in;
        mem_out     <= '0;
      end

      if (issue_c) begin
        mem_req   <= 1'b1;
        mem_we    <= MA_in[MA_RW];
        mem_addr  <= {ALU_rsl_in[DATA_W-1:OFF_W], OFF_W'(0)};
        mem_wdata <= wdata_c;
        mem_be    <= be_c;
        pc_q      <= PC_in;
        alu_q     <= ALU_rsl_in;
        rdst_q    <= Rdst_in;
        wb_q      <= WB_in;
        ld_size_q <= MA_in[MA_SIZE +: 2];
        ld_uns_q  <= MA_in[MA_UNS];
      end

      if (done_c || miss_c) begin
        mem_req     <= 1'b0;
        mem_we      <= 1'b0;
        mem_be      <= '0;
        out_valid   <= 1'b1;
        miss        <= miss_c;
        PC_out      <= pc_q;
        Rdst_out    <= rdst_q;
        ALU_rsl_out <= alu_q;
        WB_out      <= done_c ? wb_q : '0;
        mem_out     <= (done_c && !mem_we) ? ld_val_c : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized accesses
// checked against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int unsigned TO = 15;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid;
  logic [2:0]  WB_in;
  logic [4:0]  MA_in;
  logic [31:0] ALU_rsl_in, Rs2_val, PC_in, mux_wb;
  logic [4:0]  Rs2_address, Rdst_in;
  logic        OP1_MemS;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, out_valid;
  logic [31:0] PC_out, ALU_rsl_out, mem_out;
  logic [4:0]  Rdst_out, EX_MEM_Rs2;
  logic [2:0]  WB_out;
  logic [4:0]  EX_MEM_MA;
  logic        miss, misaligned;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  mem_access_stage #(.DATA_W(32), .REG_AW(5), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .WB_in(WB_in), .MA_in(MA_in),
    .ALU_rsl_in(ALU_rsl_in), .Rs2_val(Rs2_val), .Rs2_address(Rs2_address), .PC_in(PC_in),
    .Rdst_in(Rdst_in), .mux_wb(mux_wb), .OP1_MemS(OP1_MemS),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .out_valid(out_valid), .PC_out(PC_out), .Rdst_out(Rdst_out), .ALU_rsl_out(ALU_rsl_out),
    .WB_out(WB_out), .mem_out(mem_out), .EX_MEM_Rs2(EX_MEM_Rs2), .EX_MEM_MA(EX_MEM_MA),
    .miss(miss), .misaligned(misaligned)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference rules for one access, in byte-arithmetic terms
  function automatic void model(input logic [1:0] sz, input logic [31:0] addr,
                                input logic [31:0] src, input logic [31:0] rdata,
                                input logic uns, output logic fault, output logic [3:0] be,
                                output logic [31:0] wdata, output logic [31:0] ldv);
    int unsigned off;
    logic [31:0] v;
    off   = addr % 4;
    fault = 1'b0;
    be    = 4'b0000;
    wdata = 32'h0;
    ldv   = 32'h0;
    case (sz)
      2'b00: begin
        be    = 4'(1 << off);
        wdata = (src & 32'hFF) * 32'h0101_0101;
        v     = (rdata >> (8 * off)) & 32'hFF;
        ldv   = (!uns && v >= 32'h80) ? (v | 32'hFFFF_FF00) : v;
      end
      2'b01: begin
        fault = (off % 2) != 0;
        be    = 4'(3 << (off - off % 2));
        wdata = (src & 32'hFFFF) * 32'h0001_0001;
        v     = (rdata >> (8 * (off - off % 2))) & 32'hFFFF;
        ldv   = (!uns && v >= 32'h8000) ? (v | 32'hFFFF_0000) : v;
      end
      2'b10: begin
        fault = off != 0;
        be    = 4'hF;
        wdata = src;
        ldv   = rdata;
      end
      default: fault = 1'b1;
    endcase
  endfunction

  // One instruction through the stage; dly = WAIT cycles before ack (> TO means never)
  task automatic run_op(input logic en, input logic rw, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] mwb,
                        input logic sel, input logic [31:0] rdata, input int dly);
    logic        fault, done;
    logic [3:0]  be;
    logic [31:0] wd, ldv, pc;
    logic [2:0]  wb;
    logic [4:0]  rd, rs2a;
    wb   = 3'($urandom_range(1, 7));
    pc   = $urandom;
    rd   = 5'($urandom);
    rs2a = 5'($urandom);
    done = 1'b0;
    model(sz, addr, sel ? mwb : rs2, rdata, uns, fault, be, wd, ldv);

    @(negedge Clk);
    in_valid = 1'b1; WB_in = wb; MA_in = {uns, sz, rw, en}; ALU_rsl_in = addr;
    Rs2_val = rs2; mux_wb = mwb; OP1_MemS = sel; PC_in = pc; Rdst_in = rd; Rs2_address = rs2a;
    #1;
    check("ex_mem_ma", EX_MEM_MA, {uns, sz, rw, en});
    check("ex_mem_rs2", EX_MEM_Rs2, rs2a);
    check("stall_idle", stall, 0);

    @(negedge Clk);
    in_valid = 1'b0;
    if (!en || fault) begin
      check("pass_valid", out_valid, 1);
      check("pass_misaligned", misaligned, en);
      check("pass_wb", WB_out, en ? 3'd0 : wb);
      check("pass_mem_out", mem_out, 0);
      check("pass_alu", ALU_rsl_out, addr);
      check("pass_pc", PC_out, pc);
      check("pass_rdst", Rdst_out, rd);
      check("pass_no_req", mem_req, 0);
      check("pass_stall", stall, 0);
      @(negedge Clk);
      check("pass_valid_pulse", out_valid, 0);
      check("pass_misaligned_pulse", misaligned, 0);
      return;
    end

    check("req_we", mem_we, rw);
    check("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
    if (rw) check("req_wdata", mem_wdata, wd);
    for (int k = 0; k <= int'(TO); k++) begin
      if (k > 0) @(negedge Clk);
      check("req_held", mem_req, 1);
      check("req_be", mem_be, be);
      if (k == dly) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
        #1;
        check("stall_ack_cycle", stall, 0);
        done = 1'b1;
        break;
      end
      if (k < int'(TO)) check("stall_wait", stall, 1);
    end

    @(negedge Clk);
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    check("done_valid", out_valid, 1);
    check("done_miss", miss, !done);
    check("done_wb", WB_out, done ? wb : 3'd0);
    check("done_mem_out", mem_out, (done && !rw) ? ldv : 32'h0);
    check("done_pc", PC_out, pc);
    check("done_rdst", Rdst_out, rd);
    check("done_alu", ALU_rsl_out, addr);
    check("done_req_low", mem_req, 0);
    check("done_stall", stall, 0);
    @(negedge Clk);
    check("done_valid_pulse", out_valid, 0);
    check("done_miss_pulse", miss, 0);
  endtask

  initial begin
    Rst = 1'b1; in_valid = 1'b0; WB_in = '0; MA_in = '0; ALU_rsl_in = '0; Rs2_val = '0;
    Rs2_address = '0; PC_in = '0; Rdst_in = '0; mux_wb = '0; OP1_MemS = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check("rst_req", mem_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_be", mem_be, 0);
    check("rst_wb", WB_out, 0);
    @(negedge Clk);
    Rst = 1'b0;

    // ALU pass-through
    run_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 32'h0, 1'b0, 32'h0, 0);
    // Signed and unsigned byte loads from the top lane
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h0, 1'b0, 32'h80FF_FFFF, 3);
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0, 1'b0, 32'h80FF_FFFF, 3);
    // Forwarded halfword store
    run_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h102, 32'hAAAA_BEEF, 32'h0000_1234, 1'b1, 32'h0, 1);
    // Misaligned word load and reserved size
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1'b0, 32'h0, 0);
    run_op(1'b1, 1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 32'h0, 0);
    // Timeout, then ack in the timeout cycle
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, 100);
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'h0, 1'b0, 32'hCAFE_F00D, int'(TO));

    // Late ack in IDLE is ignored
    @(negedge Clk);
    mem_ack = 1'b1;
    @(negedge Clk);
    mem_ack = 1'b0;
    check("late_ack_valid", out_valid, 0);
    check("late_ack_req", mem_req, 0);

    // Reset during WAIT
    @(negedge Clk);
    in_valid = 1'b1; MA_in = 5'b01001; ALU_rsl_in = 32'h300; PC_in = 32'h44; WB_in = 3'd5;
    @(negedge Clk);
    in_valid = 1'b0;
    check("mid_req", mem_req, 1);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_pc", PC_out, 0);
    check("mid_rst_be", mem_be, 0);
    @(negedge Clk);
    Rst = 1'b0;
    run_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h5678, 32'h0, 32'h0, 1'b0, 32'h0, 0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      int dly;
      dly = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(0, 4));
      run_op(($urandom_range(0, 4) != 0), 1'($urandom), 2'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom, 1'($urandom), $urandom, dly);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
